flit_rr_arbiter: RTL and testbench

//  Shares one outgoing flit link between PORTS flit sources (valid/ready, 2-bit type + data).

---
 rtl/lisnoc_flit_pkg.sv | 23 ++
 rtl/lisnoc_rr_arbiter.sv | 48 ++++
 rtl/flit_rr_arbiter.sv | 153 +++++++++++++++
 tb/tb_flit_rr_arbiter.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/lisnoc_flit_pkg.sv
// Flit type encoding shared by flit sources, arbiters and routers.
// The type field sits in the two MSBs of every flit.
package lisnoc_flit_pkg;

    localparam int FLIT_TYPE_WIDTH = 2;

    typedef enum logic [FLIT_TYPE_WIDTH-1:0] {
        FLIT_TYPE_PAYLOAD = 2'b00,
        FLIT_TYPE_HEAD    = 2'b01,
        FLIT_TYPE_TAIL    = 2'b10,
        FLIT_TYPE_SINGLE  = 2'b11
    } flit_type_e;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_e;

    function automatic flit_type_e flit_type_of(input logic [FLIT_TYPE_WIDTH-1:0] type_bits);
        return flit_type_e'(type_bits);
    endfunction

endpackage

// File: rtl/lisnoc_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping at N-1.
// Produces both a one-hot grant and its binary index.
module lisnoc_rr_arbiter #(
    parameter int N = 4,
    localparam int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    localparam int SUM_W = IDX_W + 1;

    logic [SUM_W-1:0] pos_s;

    // Scan the requesters starting from ptr; pos_s stays below N so odd N wraps cleanly.
    always_comb begin
        pos_s = '0;
        idx   = '0;
        any   = 1'b0;
        for (int off = 0; off < N; off++) begin
            pos_s = {1'b0, ptr} + SUM_W'(off);
            if (pos_s >= SUM_W'(N)) begin
                pos_s = pos_s - SUM_W'(N);
            end else begin
                pos_s = pos_s;
            end
            if (!any && req[pos_s[IDX_W-1:0]]) begin
                any = 1'b1;
                idx = pos_s[IDX_W-1:0];
            end else begin
            end
        end
    end

    // One-hot view of the chosen index.
    always_comb begin
        gnt = '0;
        if (any) begin
            gnt[idx] = 1'b1;
        end else begin
            gnt = '0;
        end
    end

endmodule

// File: rtl/flit_rr_arbiter.sv
// Packet-granular round-robin mux of PORTS flit sources onto one registered flit link.
// A HEAD locks the link to its port until the matching TAIL; SINGLEs never lock.
module flit_rr_arbiter
    import lisnoc_flit_pkg::*;
#(
    parameter int FLIT_DATA_WIDTH = 32,
    parameter int PORTS           = 4,
    localparam int FLIT_WIDTH     = FLIT_DATA_WIDTH + FLIT_TYPE_WIDTH
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [PORTS*FLIT_WIDTH-1:0] in_flit,
    input  logic [PORTS-1:0]            in_valid,
    output logic [PORTS-1:0]            in_ready,
    output logic [FLIT_WIDTH-1:0]       out_flit,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        err
);

    localparam int IDX_W = $clog2(PORTS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PORTS - 1);

    arb_state_e            state_r, state_n_s;
    logic [IDX_W-1:0]      ptr_r, ptr_n_s, grant_r, grant_n_s;
    logic [IDX_W-1:0]      win_idx_s, sel_idx_s;
    logic [PORTS-1:0]      win_gnt_s, in_ready_s;
    logic                  win_any_s, free_s, accept_s, load_s, err_set_s;
    logic [FLIT_WIDTH-1:0] sel_flit_s, out_flit_r;
    logic                  out_valid_r, err_r;
    flit_type_e            sel_type_s;

    lisnoc_rr_arbiter #(.N(PORTS)) u_rr (
        .req (in_valid),
        .ptr (ptr_r),
        .gnt (win_gnt_s),
        .idx (win_idx_s),
        .any (win_any_s)
    );

    // Pick the port feeding the output register this cycle and decode its flit type.
    always_comb begin
        free_s     = !out_valid_r || out_ready;
        sel_idx_s  = (state_r == ST_LOCKED) ? grant_r : win_idx_s;
        sel_flit_s = in_flit[int'(sel_idx_s) * FLIT_WIDTH +: FLIT_WIDTH];
        sel_type_s = flit_type_of(sel_flit_s[FLIT_WIDTH-1 -: FLIT_TYPE_WIDTH]);
    end

    // Handshake: only the selected port may see ready, and nothing is taken while in reset.
    always_comb begin
        in_ready_s = '0;
        accept_s   = 1'b0;
        if (!rst) begin
            in_ready_s = '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (free_s && win_any_s) begin
                        in_ready_s = win_gnt_s;
                        accept_s   = 1'b1;
                    end else begin
                        in_ready_s = '0;
                    end
                end
                ST_LOCKED: begin
                    in_ready_s[grant_r] = free_s;
                    accept_s            = free_s && in_valid[grant_r];
                end
                default: begin
                    in_ready_s = '0;
                end
            endcase
        end
    end

    assign in_ready = in_ready_s;

    // Packet FSM: stray PAYLOAD/TAIL in IDLE is dropped, a nested HEAD/SINGLE is forwarded; both flag err.
    always_comb begin
        state_n_s = state_r;
        ptr_n_s   = ptr_r;
        grant_n_s = grant_r;
        load_s    = 1'b0;
        err_set_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    ptr_n_s = (win_idx_s == LAST_IDX) ? '0 : win_idx_s + IDX_W'(1);
                    case (sel_type_s)
                        FLIT_TYPE_HEAD: begin
                            load_s    = 1'b1;
                            grant_n_s = win_idx_s;
                            state_n_s = ST_LOCKED;
                        end
                        FLIT_TYPE_SINGLE: load_s    = 1'b1;
                        default:          err_set_s = 1'b1;
                    endcase
                end else begin
                    load_s = 1'b0;
                end
            end
            ST_LOCKED: begin
                if (accept_s) begin
                    load_s = 1'b1;
                    case (sel_type_s)
                        FLIT_TYPE_TAIL:   state_n_s = ST_IDLE;
                        FLIT_TYPE_HEAD:   err_set_s = 1'b1;
                        FLIT_TYPE_SINGLE: err_set_s = 1'b1;
                        default:          err_set_s = 1'b0;
                    endcase
                end else begin
                    load_s = 1'b0;
                end
            end
            default: state_n_s = ST_IDLE;
        endcase
    end

    // Arbitration state and sticky error flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
            ptr_r   <= '0;
            grant_r <= '0;
            err_r   <= 1'b0;
        end else begin
            state_r <= state_n_s;
            ptr_r   <= ptr_n_s;
            grant_r <= grant_n_s;
            err_r   <= err_r | err_set_s;
        end
    end

    // Output stage: load when free, otherwise hold; drop valid once drained.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_flit_r  <= '0;
            out_valid_r <= 1'b0;
        end else if (load_s) begin
            out_flit_r  <= sel_flit_s;
            out_valid_r <= 1'b1;
        end else if (out_ready) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    assign out_flit  = out_flit_r;
    assign out_valid = out_valid_r;
    assign err       = err_r;

endmodule

// File: tb/tb_flit_rr_arbiter.sv
// Scoreboard bench for flit_rr_arbiter: per-port source queues drive the inputs,
// the expected output order is pushed by hand, and a monitor checks each accepted flit.
module tb_flit_rr_arbiter;
    import lisnoc_flit_pkg::*;

    localparam int DW = 32;
    localparam int P  = 4;
    localparam int FW = DW + 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [P*FW-1:0] in_flit;
    logic [P-1:0]  in_valid, in_ready;
    logic [FW-1:0] out_flit;
    logic          out_valid, out_ready, err;

    logic [FW-1:0] src_q [P][$];
    logic [FW-1:0] exp_q [$];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    flit_rr_arbiter #(.FLIT_DATA_WIDTH(DW), .PORTS(P)) dut (
        .clk(clk), .rst(rst), .in_flit(in_flit), .in_valid(in_valid), .in_ready(in_ready),
        .out_flit(out_flit), .out_valid(out_valid), .out_ready(out_ready), .err(err)
    );

    function automatic logic [FW-1:0] mk(input flit_type_e t, input logic [DW-1:0] d);
        return {t, d};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    function automatic bit srcs_busy();
        for (int i = 0; i < P; i++) if (src_q[i].size() != 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || srcs_busy()) && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk(name, 64'(exp_q.size()), 64'(0));
    endtask

    task automatic wait_out(input string name);
        int n = 0;
        @(negedge clk);
        while (!out_valid && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk(name, 64'(out_valid), 64'(1'b1));
    endtask

    // Source driver: pop flits that were accepted, then present the next one.
    initial begin
        logic [P-1:0] fire;
        in_valid = '0;
        in_flit  = '0;
        forever begin
            @(negedge clk);
            fire = in_valid & in_ready;
            @(posedge clk);
            #2;
            for (int i = 0; i < P; i++) begin
                if (fire[i] && src_q[i].size() != 0) void'(src_q[i].pop_front());
                if (src_q[i].size() != 0) begin
                    in_valid[i] = 1'b1;
                    in_flit[i*FW +: FW] = src_q[i][0];
                end else begin
                    in_valid[i] = 1'b0;
                end
            end
        end
    end

    // Monitor: every flit taken by the link must be the next expected one.
    initial begin
        forever begin
            @(negedge clk);
            if (rst && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_flit: got %h expected none", out_flit);
                end else begin
                    chk("out_flit_order", 64'(out_flit), 64'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        int n;
        rst = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("reset_out_valid", 64'(out_valid), 64'(1'b0));
        chk("reset_out_flit", 64'(out_flit), 64'(0));
        chk("reset_err", 64'(err), 64'(1'b0));
        tick();
        rst = 1'b1;
        tick();

        // All ports stream SINGLEs: grant order 0,1,2,3,0,1,2,3 at one flit per cycle.
        for (int r = 0; r < 2; r++) begin
            for (int p = 0; p < P; p++) begin
                src_q[p].push_back(mk(FLIT_TYPE_SINGLE, 32'h6000_0000 + DW'(r * 16 + p)));
                exp_q.push_back(mk(FLIT_TYPE_SINGLE, 32'h6000_0000 + DW'(r * 16 + p)));
            end
        end
        wait_out("t6_first_out");
        n = 1;
        repeat (7) begin
            @(negedge clk);
            if (out_valid && out_ready) n++;
        end
        chk("t6_throughput", 64'(n), 64'(8));
        wait_drain("t6_drain");
        tick();

        // Ports 0 and 2 send 3-flit packets together: port0 whole, then port2 contiguous.
        for (int k = 0; k < 3; k++) begin
            src_q[0].push_back(mk(flit_type_e'(k == 0 ? 2'b01 : (k == 1 ? 2'b00 : 2'b10)), 32'h3000_0000 + DW'(k)));
            src_q[2].push_back(mk(flit_type_e'(k == 0 ? 2'b01 : (k == 1 ? 2'b00 : 2'b10)), 32'h3200_0000 + DW'(k)));
        end
        exp_q.push_back(mk(FLIT_TYPE_HEAD,    32'h3000_0000));
        exp_q.push_back(mk(FLIT_TYPE_PAYLOAD, 32'h3000_0001));
        exp_q.push_back(mk(FLIT_TYPE_TAIL,    32'h3000_0002));
        exp_q.push_back(mk(FLIT_TYPE_HEAD,    32'h3200_0000));
        exp_q.push_back(mk(FLIT_TYPE_PAYLOAD, 32'h3200_0001));
        exp_q.push_back(mk(FLIT_TYPE_TAIL,    32'h3200_0002));
        wait_out("t3_first_out");
        chk("t3_lock_blocks_p2", 64'(in_ready[2]), 64'(1'b0));
        n = 1;
        repeat (5) begin
            @(negedge clk);
            if (out_valid && out_ready) n++;
        end
        chk("t3_contiguous", 64'(n), 64'(6));
        wait_drain("t3_drain");
        tick();
        // Pointer now sits at port3, so port3 beats port0.
        src_q[0].push_back(mk(FLIT_TYPE_SINGLE, 32'h0000_0030));
        src_q[3].push_back(mk(FLIT_TYPE_SINGLE, 32'h0000_0033));
        exp_q.push_back(mk(FLIT_TYPE_SINGLE, 32'h0000_0033));
        exp_q.push_back(mk(FLIT_TYPE_SINGLE, 32'h0000_0030));
        wait_drain("t3_ptr_port3");
        tick();

        // Port1 packet with link back-pressure for 4 cycles.
        src_q[1].push_back(mk(FLIT_TYPE_HEAD,    32'h4100_0000));
        src_q[1].push_back(mk(FLIT_TYPE_PAYLOAD, 32'h4100_0001));
        src_q[1].push_back(mk(FLIT_TYPE_PAYLOAD, 32'h4100_0002));
        src_q[1].push_back(mk(FLIT_TYPE_TAIL,    32'h4100_0003));
        for (int k = 0; k < 4; k++) exp_q.push_back(src_q[1][k]);
        tick();
        out_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("t4_hold_valid", 64'(out_valid), 64'(1'b1));
            chk("t4_hold_flit", 64'(out_flit), 64'(mk(FLIT_TYPE_HEAD, 32'h4100_0000)));
            chk("t4_ready_low", 64'(in_ready[1]), 64'(1'b0));
        end
        tick();
        out_ready = 1'b1;
        wait_drain("t4_drain");
        tick();

        // Stray TAIL in IDLE: accepted, dropped, error flagged.
        src_q[3].push_back(mk(FLIT_TYPE_TAIL, 32'hdead_beef));
        @(negedge clk);
        chk("t5_ready3", 64'(in_ready[3]), 64'(1'b1));
        chk("t5_err_before", 64'(err), 64'(1'b0));
        @(negedge clk);
        chk("t5_no_output", 64'(out_valid), 64'(1'b0));
        chk("t5_err", 64'(err), 64'(1'b1));
        tick();

        // Port0 SINGLE: one cycle of latency, err remains sticky.
        src_q[0].push_back(mk(FLIT_TYPE_SINGLE, 32'h0123_4567));
        exp_q.push_back(mk(FLIT_TYPE_SINGLE, 32'h0123_4567));
        @(negedge clk);
        chk("t2_ready0", 64'(in_ready[0]), 64'(1'b1));
        chk("t2_not_yet", 64'(out_valid), 64'(1'b0));
        @(negedge clk);
        chk("t2_valid", 64'(out_valid), 64'(1'b1));
        chk("t2_flit", 64'(out_flit), 64'(34'h3_0123_4567));
        chk("t2_err_sticky", 64'(err), 64'(1'b1));
        wait_drain("t2_drain");
        tick();

        // Reset in the middle of a stalled packet.
        out_ready = 1'b0;
        src_q[1].push_back(mk(FLIT_TYPE_HEAD,    32'h1100_0000));
        src_q[1].push_back(mk(FLIT_TYPE_PAYLOAD, 32'h1100_0001));
        src_q[1].push_back(mk(FLIT_TYPE_PAYLOAD, 32'h1100_0002));
        repeat (3) @(negedge clk);
        chk("t1_stalled_valid", 64'(out_valid), 64'(1'b1));
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("t1_out_valid", 64'(out_valid), 64'(1'b0));
        chk("t1_out_flit", 64'(out_flit), 64'(0));
        chk("t1_in_ready", 64'(in_ready), 64'(0));
        chk("t1_err", 64'(err), 64'(1'b0));
        for (int i = 0; i < P; i++) src_q[i].delete();
        tick();
        tick();
        rst = 1'b1;
        out_ready = 1'b1;
        // Pointer is back at 0 after reset, so port0 precedes port2.
        src_q[2].push_back(mk(FLIT_TYPE_SINGLE, 32'h7200_0000));
        src_q[0].push_back(mk(FLIT_TYPE_SINGLE, 32'h7000_0000));
        exp_q.push_back(mk(FLIT_TYPE_SINGLE, 32'h7000_0000));
        exp_q.push_back(mk(FLIT_TYPE_SINGLE, 32'h7200_0000));
        wait_drain("t1_recover");
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
